regfile: RTL and testbench



---
 rtl/regfile.sv | 45 ++++
 tb/tb_regfile.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// 8 x 16-bit register file with two combinational read ports, a general write
// port and a dedicated program-counter (R7) update port.
module regfile #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned PC_IDX = 7
) (
   input  logic              clk,
   input  logic              rst,
   output logic [WIDTH-1:0]  data_out1,
   output logic [WIDTH-1:0]  data_out2,
   input  logic [WIDTH-1:0]  data_in,
   input  logic [WIDTH-1:0]  R7_in,
   input  logic [ADDR_W-1:0] sr1,
   input  logic [ADDR_W-1:0] sr2,
   input  logic [ADDR_W-1:0] wr,
   input  logic              write_en,
   input  logic              R7_en
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

   logic [DEPTH-1:0][WIDTH-1:0] regs;

   // The general write is issued after the PC update so a writeback to R7
   // overrides the fetch-stage increment on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs <= '0;
      end else begin
         if (R7_en) begin
            regs[PC_ADDR] <= R7_in;
         end
         if (write_en) begin
            regs[wr] <= data_in;
         end
      end
   end

   // Zero-latency reads; no write-to-read bypass.
   assign data_out1 = regs[sr1];
   assign data_out2 = regs[sr2];

endmodule

// File: tb/tb_regfile.sv
// Directed testbench for regfile: a per-cycle array model plus literal checks
// for reset, sequential writes, the R7 port, port conflicts and async reset.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_out1;
   logic [15:0] data_out2;
   logic [15:0] data_in;
   logic [15:0] R7_in;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [2:0]  wr;
   logic        write_en;
   logic        R7_en;

   int errors = 0;
   int checks = 0;
   bit auto_en = 1'b0;

   logic [15:0] mdl [8] = '{default: 16'h0000};

   regfile #(.WIDTH(16), .ADDR_W(3), .PC_IDX(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_out1 (data_out1),
      .data_out2 (data_out2),
      .data_in   (data_in),
      .R7_in     (R7_in),
      .sr1       (sr1),
      .sr2       (sr2),
      .wr        (wr),
      .write_en  (write_en),
      .R7_en     (R7_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: eight plain words; reset empties them, an edge commits the PC
   // port first and then lets the general port overwrite.
   always @(posedge clk or negedge rst) begin
      if (rst !== 1'b1) begin
         for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
      end else begin
         if (R7_en === 1'b1) mdl[7] = R7_in;
         if (write_en === 1'b1) mdl[int'(wr)] = data_in;
      end
   end

   // Per-cycle comparison of both read ports against the reference.
   always @(negedge clk) begin
      if (auto_en) begin
         check("port1_vs_model", data_out1, mdl[int'(sr1)]);
         check("port2_vs_model", data_out2, mdl[int'(sr2)]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sweep_zero(input string name);
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i);
         sr2 = 3'(7 - i);
         #1;
         check(name, data_out1, 16'h0000);
         check(name, data_out2, 16'h0000);
      end
   endtask

   initial begin
      rst = 1'b0;
      data_in = '0; R7_in = '0; sr1 = '0; sr2 = '0; wr = '0;
      write_en = 1'b0; R7_en = 1'b0;
      #3;
      auto_en = 1'b1;
      sweep_zero("reads_in_reset");

      // Release reset between clock edges.
      @(negedge clk);
      #2;
      rst = 1'b1;
      step();
      sweep_zero("reads_after_reset");

      // Sequential writes R0..R6 = 10*k.
      for (int k = 0; k < 7; k++) begin
         wr = 3'(k);
         data_in = 16'(10 * k);
         write_en = 1'b1;
         step();
      end
      write_en = 1'b0;
      sr1 = 3'd0; sr2 = 3'd1; #1;
      check("seq_r0", data_out1, 16'd0);  check("seq_r1", data_out2, 16'd10);
      sr1 = 3'd2; sr2 = 3'd3; #1;
      check("seq_r2", data_out1, 16'd20); check("seq_r3", data_out2, 16'd30);
      sr1 = 3'd4; sr2 = 3'd5; #1;
      check("seq_r4", data_out1, 16'd40); check("seq_r5", data_out2, 16'd50);
      sr1 = 3'd6; sr2 = 3'd7; #1;
      check("seq_r6", data_out1, 16'd60); check("seq_r7", data_out2, 16'd0);

      // Dedicated R7 port.
      R7_en = 1'b1; R7_in = 16'd122;
      step();
      R7_en = 1'b0;
      sr1 = 3'd7; #1;
      check("r7_port", data_out1, 16'd122);
      for (int i = 0; i < 7; i++) begin
         sr2 = 3'(i); #1;
         check("r7_port_others", data_out2, 16'(10 * i));
      end

      // Conflict: general port wins, then PC port alone.
      write_en = 1'b1; wr = 3'd7; data_in = 16'h1234;
      R7_en = 1'b1; R7_in = 16'h00FF;
      step();
      write_en = 1'b0;
      sr1 = 3'd7; #1;
      check("conflict_general_wins", data_out1, 16'h1234);
      step();
      R7_en = 1'b0;
      check("r7_only_next", data_out1, 16'h00FF);

      // Both ports, different targets.
      write_en = 1'b1; wr = 3'd2; data_in = 16'hAAAA;
      R7_en = 1'b1; R7_in = 16'h5555;
      step();
      write_en = 1'b0; R7_en = 1'b0;
      sr1 = 3'd2; sr2 = 3'd7; #1;
      check("dual_r2", data_out1, 16'hAAAA);
      check("dual_r7", data_out2, 16'h5555);

      // Read during write, then hold.
      sr1 = 3'd3; wr = 3'd3; data_in = 16'hBEEF; write_en = 1'b1; #1;
      check("rdw_old", data_out1, 16'd30);
      step();
      check("rdw_new", data_out1, 16'hBEEF);
      write_en = 1'b0; data_in = 16'h1111;
      step();
      data_in = 16'h2222;
      step();
      check("hold_r3", data_out1, 16'hBEEF);

      // Async reset between edges, write attempt while in reset.
      #2;
      sr1 = 3'd3; sr2 = 3'd7;
      rst = 1'b0; #1;
      check("async_r3", data_out1, 16'h0000);
      check("async_r7", data_out2, 16'h0000);
      write_en = 1'b1; wr = 3'd1; data_in = 16'hFFFF;
      R7_en = 1'b1; R7_in = 16'hFFFF;
      step();
      write_en = 1'b0; R7_en = 1'b0;
      sweep_zero("write_during_reset");
      @(negedge clk);
      #2;
      rst = 1'b1;
      step();
      sweep_zero("after_second_reset");

      step();
      auto_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
